// File: rtl/bist_mem_if.sv
// RAM-side bus of the March BIST controller: write data, address, read/write
// select and the RAM's registered read data.
interface bist_mem_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_q;

  modport master (output mem_data, output mem_addr, output mem_re, input mem_q);
  modport slave  (input mem_data, input mem_addr, input mem_re, output mem_q);
endinterface

// File: rtl/bist_march_ctrl.sv
// March C- BIST controller: issues one RAM operation per cycle through six
// elements, compares each read one edge later and latches pass/fail status.
module bist_march_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  bist_mem_if.master        mem,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  err_count
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] BG_ZERO   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] BG_ONES   = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  function automatic logic is_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // E1..E4 are read-then-write at each address; E0 only writes, E5 only reads.
  function automatic logic is_rw(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic [DATA_W-1:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? BG_ONES : BG_ZERO;
  endfunction

  function automatic logic [DATA_W-1:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? BG_ONES : BG_ZERO;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_re_q, mem_re_d;
  logic              busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;
  logic              last_s;

  // Operation sequencing, read compare and status update.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_re_d    = 1'b1;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    err_d       = err_q;
    pend_d      = 1'b0;
    exp_d       = exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    last_s      = is_desc(elem_q) ? (mem_addr_q == ADDR_ZERO) : (mem_addr_q == ADDR_MAX);

    // mem_q belongs to the read presented last cycle, before any same-address write lands.
    if (pend_q && (mem.mem_q != exp_q)) begin
      err_d = (err_q == CNT_MAX) ? err_q : (err_q + CNT_ONE);
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
        fail_data_d = mem.mem_q;
      end else begin
        fail_d = fail_q;
      end
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          mem_addr_d  = ADDR_ZERO;
          mem_data_d  = wr_bg(3'd0);
          mem_re_d    = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = ADDR_ZERO;
          fail_elem_d = 3'd0;
          fail_data_d = BG_ZERO;
          err_d       = CNT_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        pend_d     = mem_re_q;
        exp_d      = rd_bg(elem_q);
        cmp_addr_d = mem_addr_q;
        cmp_elem_d = elem_q;
        if (is_rw(elem_q) && mem_re_q) begin
          mem_re_d   = 1'b0;
          mem_data_d = wr_bg(elem_q);
        end else if (!last_s) begin
          mem_addr_d = is_desc(elem_q) ? (mem_addr_q - ADDR_ONE) : (mem_addr_q + ADDR_ONE);
          mem_re_d   = (elem_q != 3'd0);
          mem_data_d = wr_bg(elem_q);
        end else if (elem_q == 3'd5) begin
          state_d = S_DRAIN;
        end else begin
          // Every element after E0 opens with a read at its starting address.
          elem_d     = elem_q + 3'd1;
          mem_addr_d = is_desc(elem_q + 3'd1) ? ADDR_MAX : ADDR_ZERO;
          mem_re_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset forces a read so the RAM is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      mem_addr_q  <= ADDR_ZERO;
      mem_data_q  <= BG_ZERO;
      mem_re_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_elem_q <= 3'd0;
      fail_data_q <= BG_ZERO;
      err_q       <= CNT_ZERO;
      pend_q      <= 1'b0;
      exp_q       <= BG_ZERO;
      cmp_addr_q  <= ADDR_ZERO;
      cmp_elem_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_data = mem_data_q;
  assign mem.mem_re   = mem_re_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign fail_addr    = fail_addr_q;
  assign fail_elem    = fail_elem_q;
  assign fail_data    = fail_data_q;
  assign err_count    = err_q;
endmodule
